// File: rtl/chroma_upsampler.sv
// -----------------------------------------------------------------------------
// chroma_upsampler
//
// Horizontal 4:2:2 -> 4:4:4 chroma upsampler. Half-width U and V planes are read
// from a 16-bit-word SRAM, the missing odd-column samples are interpolated, and
// full-width U and V planes are written back in ascending address order.
//
// Each source word packs two 8-bit samples (sample 2k in [7:0], sample 2k+1 in
// [15:8]). Each output word is {odd pixel 2j+1, even pixel 2j}, one per source
// sample j. The U plane is processed first, then the V plane. Each row is
// processed left to right, and no data crosses a row boundary.
//
// Interpolation (default): 6-tap FIR
//   (21, -52, 159, 159, -52, 21) over C[j-2..j+3], rounded, >>> 8, clamped to
//   0..255. Indices are edge-replicated within the row.
// Optional build macro BILINEAR_EN: odd = (C[j] + C[j+1] + 1) >> 1, using a
//   2-sample window and a shorter row preload.
//
// Ports:
//   clk    in   1   clock, all state on rising edge
//   rst    in   1   asynchronous active-high reset, aborts any frame
//   start  in   1   one-cycle pulse, begins a frame (sampled in IDLE only)
//   rdata  in  16   SRAM read data, valid the cycle after ren
//   ren    out  1   SRAM read enable
//   raddr  out 18   SRAM read address
//   wen    out  1   SRAM write enable
//   waddr  out 18   SRAM write address
//   wdata  out 16   SRAM write data
//   busy   out  1   high from the cycle after an accepted start through done
//   done   out  1   one-cycle pulse after the final write
// -----------------------------------------------------------------------------
module chroma_upsampler #(
    parameter int W          = 320,
    parameter int H          = 240,
    parameter int SRC_U_BASE = 115200,
    parameter int SRC_V_BASE = 134400,
    parameter int DST_U_BASE = 38400,
    parameter int DST_V_BASE = 76800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] rdata,
    output logic        ren,
    output logic [17:0] raddr,
    output logic        wen,
    output logic [17:0] waddr,
    output logic [15:0] wdata,
    output logic        busy,
    output logic        done
);

    // Samples per row (N) and source words per row (NW).
    localparam int N  = W / 2;
    localparam int NW = W / 4;

`ifdef BILINEAR_EN
    // The window holds C[j], C[j+1]. One word is preloaded per row.
    localparam int WIN = 2;
    localparam int PRE = 1;
    localparam int CTR = 0;
`else
    // The window holds C[j-2..j+3]. Two words are preloaded per row.
    localparam int WIN = 6;
    localparam int PRE = 2;
    localparam int CTR = 2;
`endif

    // In step j, the window takes in sample j + NEXT_OFF.
    localparam int NEXT_OFF = 2 * PRE;
    localparam int SW       = $clog2(N + NEXT_OFF + 2);
    localparam int RW       = $clog2(H + 1);

    localparam logic [SW-1:0] N_S       = SW'(N);
    localparam logic [SW-1:0] NW_S      = SW'(NW);
    localparam logic [SW-1:0] OFF_S     = SW'(NEXT_OFF);
    localparam logic [SW-1:0] LAST_J    = SW'(N - 1);
    localparam logic [1:0]    LOAD_LAST = 2'(PRE + 1);
    localparam logic [RW-1:0] LAST_ROW  = RW'(H - 1);

    localparam logic [17:0] SRC_U_A    = 18'(SRC_U_BASE);
    localparam logic [17:0] SRC_V_A    = 18'(SRC_V_BASE);
    localparam logic [17:0] DST_U_A    = 18'(DST_U_BASE);
    localparam logic [17:0] DST_V_A    = 18'(DST_V_BASE);
    localparam logic [17:0] ROW_STRIDE = 18'(NW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW_LOAD,
        S_ROW_RUN,
        S_ROW_NEXT,
        S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             ld_q, ld_d;          // preload cycle counter
    logic [SW-1:0]          step_q, step_d;      // current sample j in row
    logic [SW-1:0]          rd_idx_q, rd_idx_d;  // next source word to read
    logic [RW-1:0]          row_q, row_d;
    logic                   plane_q, plane_d;    // 0 = U, 1 = V
    logic [17:0]            src_row_q, src_row_d;
    logic [17:0]            wr_ptr_q, wr_ptr_d;
    logic [WIN-1:0][7:0]    win_q, win_d;        // win[0] is the oldest sample
    logic [7:0]             hi_q, hi_d;          // upper sample of last word read
    logic                   ren_q, ren_d;
    logic [17:0]            raddr_q, raddr_d;
    logic                   wen_q, wen_d;
    logic [17:0]            waddr_q, waddr_d;
    logic [15:0]            wdata_q, wdata_d;

    logic [7:0]             odd_pix;
    logic                   next_valid;
    logic [7:0]             next_sample;

    // ------------------------------------------------------------------
    // Odd-pixel interpolation from the current window
    // ------------------------------------------------------------------
`ifdef BILINEAR_EN
    logic [8:0] bl_sum;

    always_comb begin
        bl_sum  = {1'b0, win_q[0]} + {1'b0, win_q[1]} + 9'd1;
        odd_pix = bl_sum[8:1];
    end
`else
    logic signed [19:0] acc;
    logic signed [19:0] acc_sh;

    function automatic logic signed [19:0] sx(input logic [7:0] s);
        return $signed({12'd0, s});
    endfunction

    always_comb begin
        acc = 20'sd21  * sx(win_q[0]) - 20'sd52  * sx(win_q[1])
            + 20'sd159 * sx(win_q[2]) + 20'sd159 * sx(win_q[3])
            - 20'sd52  * sx(win_q[4]) + 20'sd21  * sx(win_q[5])
            + 20'sd128;
        acc_sh = acc >>> 8;
        if (acc_sh < 20'sd0) begin
            odd_pix = 8'd0;
        end else if (acc_sh > 20'sd255) begin
            odd_pix = 8'd255;
        end else begin
            odd_pix = acc_sh[7:0];
        end
    end
`endif

    // The sample entering the window is either fresh (from rdata on even
    // steps, or the buffered upper half on odd steps) or, beyond the right
    // edge of the row, a replica of the newest sample already held.
    always_comb begin
        next_valid = (step_q + OFF_S) < N_S;
        if (!next_valid) begin
            next_sample = win_q[WIN-1];
        end else if (!step_q[0]) begin
            next_sample = rdata[7:0];
        end else begin
            next_sample = hi_q;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    // NOTE: every signal gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        ld_d      = ld_q;
        step_d    = step_q;
        rd_idx_d  = rd_idx_q;
        row_d     = row_q;
        plane_d   = plane_q;
        src_row_d = src_row_q;
        wr_ptr_d  = wr_ptr_q;
        win_d     = win_q;
        hi_d      = hi_q;
        ren_d     = 1'b0;
        raddr_d   = raddr_q;
        wen_d     = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_ROW_LOAD;
                    ld_d      = 2'd0;
                    step_d    = '0;
                    rd_idx_d  = '0;
                    row_d     = '0;
                    plane_d   = 1'b0;
                    src_row_d = SRC_U_A;
                    wr_ptr_d  = DST_U_A;
                end
            end

            S_ROW_LOAD: begin
                // Issue reads for words 0..PRE back to back. Word PRE is
                // consumed by the first run step as it arrives.
                if (ld_q < LOAD_LAST && rd_idx_q < NW_S) begin
                    ren_d    = 1'b1;
                    raddr_d  = src_row_q + 18'(rd_idx_q);
                    rd_idx_d = rd_idx_q + 1'b1;
                end
`ifdef BILINEAR_EN
                if (ld_q == 2'd2) begin
                    win_d[0] = rdata[7:0];
                    win_d[1] = rdata[15:8];
                end
`else
                // Word 0 seeds the left-edge history C[-2] = C[-1] = C[0].
                if (ld_q == 2'd2) begin
                    win_d[0] = rdata[7:0];
                    win_d[1] = rdata[7:0];
                    win_d[2] = rdata[7:0];
                    win_d[3] = rdata[15:8];
                end
                if (ld_q == 2'd3) begin
                    win_d[4] = rdata[7:0];
                    win_d[5] = rdata[15:8];
                end
`endif
                if (ld_q == LOAD_LAST) begin
                    state_d = S_ROW_RUN;
                    step_d  = '0;
                end else begin
                    ld_d = ld_q + 2'd1;
                end
            end

            S_ROW_RUN: begin
                wen_d    = 1'b1;
                waddr_d  = wr_ptr_q;
                wdata_d  = {odd_pix, win_q[CTR]};
                wr_ptr_d = wr_ptr_q + 18'd1;

                // An even step consumes the low half of the word arriving
                // now and requests the word needed two steps later.
                if (!step_q[0]) begin
                    if (next_valid) begin
                        hi_d = rdata[15:8];
                    end
                    if (rd_idx_q < NW_S) begin
                        ren_d    = 1'b1;
                        raddr_d  = src_row_q + 18'(rd_idx_q);
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end

                for (int k = 0; k < WIN - 1; k++) begin
                    win_d[k] = win_q[k+1];
                end
                win_d[WIN-1] = next_sample;

                if (step_q == LAST_J) begin
                    state_d = S_ROW_NEXT;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end

            S_ROW_NEXT: begin
                ld_d     = 2'd0;
                step_d   = '0;
                rd_idx_d = '0;
                if (row_q == LAST_ROW) begin
                    if (!plane_q) begin
                        plane_d   = 1'b1;
                        row_d     = '0;
                        src_row_d = SRC_V_A;
                        wr_ptr_d  = DST_V_A;
                        state_d   = S_ROW_LOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    row_d     = row_q + 1'b1;
                    src_row_d = src_row_q + ROW_STRIDE;
                    state_d   = S_ROW_LOAD;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value, independent of statement order.
    // NOTE: only control and output flops are reset. Window and buffer
    // contents are always rewritten during ROW_LOAD before they are used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ld_q      <= 2'd0;
            step_q    <= '0;
            rd_idx_q  <= '0;
            row_q     <= '0;
            plane_q   <= 1'b0;
            src_row_q <= '0;
            wr_ptr_q  <= '0;
            ren_q     <= 1'b0;
            raddr_q   <= '0;
            wen_q     <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            ld_q      <= ld_d;
            step_q    <= step_d;
            rd_idx_q  <= rd_idx_d;
            row_q     <= row_d;
            plane_q   <= plane_d;
            src_row_q <= src_row_d;
            wr_ptr_q  <= wr_ptr_d;
            ren_q     <= ren_d;
            raddr_q   <= raddr_d;
            wen_q     <= wen_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        win_q <= win_d;
        hi_q  <= hi_d;
    end

    assign ren   = ren_q;
    assign raddr = raddr_q;
    assign wen   = wen_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);

endmodule
